uart_lite_tx_sequencer: RTL

//  AXI4-Lite master that feeds the axi_uartlite TX path from the 16-bit word handshake (data/valid/ready).

---
 rtl/uart_lite_tx_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_lite_tx_sequencer.sv
// uart_lite_tx_sequencer: AXI4-Lite master that pushes 16-bit producer words into
// an axi_uartlite TX FIFO. It clears the FIFOs once after reset, then for every
// accepted word it polls STAT until the TX FIFO has room and writes one byte,
// twice per word.
module uart_lite_tx_sequencer #(
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          INIT_RST   = 1'b1,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        valid,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [3:0]  awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    S_INIT_W, S_INIT_B, S_IDLE, S_RD_A, S_RD_R, S_WR, S_WR_B
  } state_t;

  localparam state_t      RST_STATE = state_t'(INIT_RST ? S_INIT_W : S_IDLE);
  localparam logic [15:0] LIMIT     = 16'(POLL_LIMIT);

  state_t      r_state;
  logic [15:0] r_data;
  logic        r_byte_idx;
  logic [15:0] r_poll_cnt;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_aw_ok;
  logic        w_w_ok;
  logic        w_full;
  logic [15:0] w_poll_next;
  logic        w_timeout;
  logic        w_sel_hi;
  logic [7:0]  w_byte;
  logic        w_unused_rdata;

  // A write channel counts as finished if it completed earlier or is completing now.
  assign w_aw_ok     = r_aw_done | (awvalid & awready);
  assign w_w_ok      = r_w_done  | (wvalid  & wready);
  // A failed STAT read is treated like a full FIFO so the byte is never written blind.
  assign w_full      = rdata[3] | (rresp != 2'b00);
  assign w_poll_next = r_poll_cnt + 16'd1;
  assign w_timeout   = (LIMIT != 16'd0) && (w_poll_next >= LIMIT);
  assign w_sel_hi    = ((r_byte_idx == 1'b0) == MSB_FIRST);
  assign w_byte      = w_sel_hi ? r_data[15:8] : r_data[7:0];
  assign w_unused_rdata = ^{rdata[31:4], rdata[2:0]};

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state != S_IDLE);

  // Word capture; only meaningful while a transfer is in progress, so no reset.
  always_ff @(posedge clk) begin
    if (ready && valid) r_data <= data;
  end

  // Sequencer FSM with registered AXI outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RST_STATE;
      awaddr     <= 4'h0;
      awvalid    <= 1'b0;
      wdata      <= 32'h0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      araddr     <= 4'h0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      err        <= 1'b0;
      r_byte_idx <= 1'b0;
      r_poll_cnt <= 16'd0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      err    <= 1'b0;
      araddr <= 4'h8;
      case (r_state)
        S_INIT_W, S_WR: begin
          if (r_state == S_INIT_W) begin
            awaddr <= 4'hC;
            wdata  <= 32'h3;
          end
          // Each channel drops its valid on its own handshake; a channel that has
          // not yet been offered (first cycle after reset) is raised here.
          if (awvalid && awready) begin
            awvalid   <= 1'b0;
            r_aw_done <= 1'b1;
          end else if (!r_aw_done) begin
            awvalid <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid   <= 1'b0;
            r_w_done <= 1'b1;
          end else if (!r_w_done) begin
            wvalid <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            bready    <= 1'b1;
            r_state   <= (r_state == S_INIT_W) ? S_INIT_B : S_WR_B;
          end
        end
        S_INIT_B, S_WR_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) err <= 1'b1;
            if (r_state == S_WR_B && r_byte_idx == 1'b0) begin
              r_byte_idx <= 1'b1;
              r_poll_cnt <= 16'd0;
              arvalid    <= 1'b1;
              r_state    <= S_RD_A;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (valid) begin
            r_byte_idx <= 1'b0;
            r_poll_cnt <= 16'd0;
            arvalid    <= 1'b1;
            r_state    <= S_RD_A;
          end
        end
        S_RD_A: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp != 2'b00) err <= 1'b1;
            if (w_full) begin
              r_poll_cnt <= w_poll_next;
              if (w_timeout) begin
                err     <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                arvalid <= 1'b1;
                r_state <= S_RD_A;
              end
            end else begin
              awaddr    <= 4'h4;
              wdata     <= {24'h0, w_byte};
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
